// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NROW   = 4;
    localparam int NCOL   = 4;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        PRESS_DEB   = 2'd1,
        RELEASE_DEB = 2'd2
    } state_t;

    function automatic logic [NCOL-1:0] col_strobe(input logic [1:0] idx);
        col_strobe = ~(4'b0001 << idx);
    endfunction

    // Lowest closed (low) row wins when several rows read low together.
    function automatic logic [1:0] lowest_low_row(input logic [NROW-1:0] rows);
        casez (rows)
            4'b???0: lowest_low_row = 2'd0;
            4'b??01: lowest_low_row = 2'd1;
            4'b?011: lowest_low_row = 2'd2;
            4'b0111: lowest_low_row = 2'd3;
            default: lowest_low_row = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles high (no key).
module kp_sync2
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NROW-1:0] d_i,
    output logic [NROW-1:0] q_o
);
    logic [NROW-1:0] meta_q;
    logic [NROW-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce and a valid/ack key port.
// Optional auto-repeat while a key is held: define AUTOREPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 2700,
    parameter int DEB_CYC  = 54000
`ifdef AUTOREPEAT_EN
    ,
    parameter int REP_DLY  = 13500000,
    parameter int REP_PER  = 2700000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NROW-1:0]   row_i,
    output logic [NCOL-1:0]   col_o,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              overflow
);
    localparam int CNT_MAX = (SCAN_DIV > DEB_CYC) ? SCAN_DIV : DEB_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    logic [NROW-1:0]   rs_s;
    logic              rs_row_s;
    logic              acc_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic              started_q;
    logic [NCOL-1:0]   col_o_q, col_o_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              overflow_q, overflow_d;

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DLY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PER - 1);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_SAT   = {REP_W{1'b1}};

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
`endif

    kp_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_i),
        .q_o   (rs_s)
    );

    assign rs_row_s = rs_s[row_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // started_q holds off the column timer for the one cycle col_o leaves its reset value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_s   = 1'b0;
`ifdef AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            SCAN: begin
                if (!started_q) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (cnt_q >= SCAN_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (rs_s == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = lowest_low_row(rs_s);
                        state_d = PRESS_DEB;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS_DEB: begin
                if (rs_row_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (cnt_q >= DEB_LAST) begin
                    acc_s   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RELEASE_DEB;
`ifdef AUTOREPEAT_EN
                    rep_cnt_d   = {REP_W{1'b0}};
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            RELEASE_DEB: begin
                if (!rs_row_s) begin
                    cnt_d = {CNT_W{1'b0}};
`ifdef AUTOREPEAT_EN
                    if ((rep_first_q && (rep_cnt_q >= REP_FIRST)) ||
                        (!rep_first_q && (rep_cnt_q >= REP_NEXT))) begin
                        acc_s       = 1'b1;
                        rep_cnt_d   = {REP_W{1'b0}};
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = (rep_cnt_q == REP_SAT) ? rep_cnt_q : rep_cnt_q + REP_ONE;
                    end
`endif
                end else if (cnt_q >= DEB_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // An accept while an unconsumed key is pending is dropped unless acked in that cycle.
    always_comb begin
        col_o_d     = col_strobe(col_d);
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = overflow_q;
        if (acc_s) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = {row_q, col_q};
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= {CNT_W{1'b0}};
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            started_q   <= 1'b0;
            col_o_q     <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            started_q   <= 1'b1;
            col_o_q     <= col_o_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= {REP_W{1'b0}};
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign col_o     = col_o_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, expected-code queue and monitor.
module tb_keypad_scan_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overflow;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    logic        prev_valid;
    logic [3:0]  prev_code;
    int          n_pass;
    int          n_total;

    keypad_scan_ctrl #(
        .SCAN_DIV (4),
        .DEB_CYC  (8)
`ifdef AUTOREPEAT_EN
        ,
        .REP_DLY  (20),
        .REP_PER  (10)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_i     (row_i),
        .col_o     (col_o),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a closed key pulls its row low while its column is strobed.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // A delivery is key_valid rising or a new code loaded while valid stays high.
    always @(negedge clk) begin
        if (rst_n && key_valid && (!prev_valid || key_code != prev_code)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_key", {28'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
                chk("key_code_sb", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
        prev_valid <= key_valid;
        prev_code  <= key_code;
    end

    task automatic wait_col(input logic [3:0] tgt, input bit want_eq, input string name);
        int n;
        n = 0;
        while (((col_o == tgt) != want_eq) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(name, 32'd0, 32'd1);
    endtask

    // Close key k just before its column is next strobed; returns on the first strobed negedge.
    task automatic press_enter(input int k, input logic [3:0] strobe);
        wait_col(strobe, 1'b0, "col_leave_timeout");
        keys[k] = 1'b1;
        wait_col(strobe, 1'b1, "col_enter_timeout");
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!key_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] strobes [4];
        int n;
        strobes[0] = 4'b1110; strobes[1] = 4'b1101;
        strobes[2] = 4'b1011; strobes[3] = 4'b0111;
        n_pass = 0; n_total = 0;
        keys = 16'h0000; key_ack = 1'b0; rst_n = 1'b0;
        prev_valid = 1'b0; prev_code = 4'h0;

        // 1: reset values and the scan walk with wrap
        repeat (3) @(negedge clk);
        chk("rst_col_o", {28'd0, col_o}, 32'hF);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("scan_walk", {28'd0, col_o}, {28'd0, strobes[(i / 4) % 4]});
        end

        // 2: row2/col1 -> code 9, 12 clk after col1 is strobed (2 sync + 2 scan + 8 debounce)
        exp_q.push_back(4'd9);
        press_enter(9, 4'b1101);
        wait_valid(40, n);
        chk("press_latency", n, 32'd12);
        keys = 16'h0000;
        repeat (50) @(negedge clk);
        chk("hold_code", {28'd0, key_code}, 32'd9);
        chk("hold_valid", {31'd0, key_valid}, 32'd1);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ack_clears", {31'd0, key_valid}, 32'd0);
        repeat (30) @(negedge clk);

        // 3: row0/col3 seen low for 5 debounce cycles, then released
        press_enter(3, 4'b0111);
        repeat (7) @(negedge clk);
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        chk("bounce_hold_col", {28'd0, col_o}, 32'h7);
        @(negedge clk);
        chk("bounce_next_col0", {28'd0, col_o}, 32'hE);
        repeat (20) @(negedge clk);
        chk("bounce_no_valid", {31'd0, key_valid}, 32'd0);

        // 4: second press (6) while 3 is unconsumed is dropped
        exp_q.push_back(4'd3);
        keys[3] = 1'b1;
        wait_valid(200, n);
        keys = 16'h0000;
        repeat (30) @(negedge clk);
        keys[6] = 1'b1;
        n = 0;
        while (!overflow && n < 200) begin
            @(negedge clk);
            n++;
        end
        keys = 16'h0000;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_code_kept", {28'd0, key_code}, 32'd3);
        chk("ovf_valid", {31'd0, key_valid}, 32'd1);
        repeat (30) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ovf_ack_valid", {31'd0, key_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // 5: ack in the accept cycle of a second key loads it without overflow
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'd0);
        keys[0] = 1'b1;
        wait_valid(200, n);
        keys = 16'h0000;
        repeat (30) @(negedge clk);
        exp_q.push_back(4'd15);
        press_enter(15, 4'b0111);
        repeat (11) @(negedge clk);
        chk("pre_accept_code", {28'd0, key_code}, 32'd0);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ack_accept_valid", {31'd0, key_valid}, 32'd1);
        chk("ack_accept_code", {28'd0, key_code}, 32'd15);
        chk("ack_accept_ovf", {31'd0, overflow}, 32'd0);
        keys = 16'h0000;
        repeat (30) @(negedge clk);

        // 6: reset during press debounce
        press_enter(10, 4'b1011);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        keys = 16'h0000;
        @(negedge clk);
        chk("midrst_col_o", {28'd0, col_o}, 32'hF);
        chk("midrst_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_code", {28'd0, key_code}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_scan", {28'd0, col_o}, {28'd0, strobes[i / 4]});
        end

`ifdef AUTOREPEAT_EN
        // Auto-repeat: key 5 held with ack high -> deliveries at +0, +20, +30, +40
        repeat (10) @(negedge clk);
        key_ack = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(4'd5);
        keys[5] = 1'b1;
        wait_valid(200, n);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 19 || j == 29 || j == 39) chk("rep_gap", {31'd0, key_valid}, 32'd0);
            if (j == 20 || j == 30 || j == 40) chk("rep_fire", {31'd0, key_valid}, 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        keys = 16'h0000;
        repeat (30) @(negedge clk);
        key_ack = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
